// File: rtl/bb_var_pkg.sv
// Shared types and helpers for the sample-counted variable delay line.
package bb_pkg;

    // Control state: FILL while the buffer holds fewer than D_lat samples, RUN once it is primed.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } bb_state_t;

    // Width needed to express any delay from 0 to max_delay inclusive.
    function automatic int bb_delay_w(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // (a - b) mod m for a < m and b <= m; works for any m, not just powers of two.
    function automatic logic [31:0] bb_mod_sub(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] m);
        return (a >= b) ? (a - b) : (a + m - b);
    endfunction

endpackage

// File: rtl/bb_var_ram.sv
// Simple dual-port buffer: registered write, combinational read.
// A read and write to the same address in one cycle returns the old word.
module bb_var_ram
    import bb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bb_var.sv
// Programmable-depth delay line counted in valid samples rather than clocks.
// Samples go into a circular buffer and come back D_lat valid samples later;
// idle cycles freeze everything, and any delay change restarts the fill.
module bb_var
    import bb_pkg::*;
#(
    parameter int               MAX_DELAY = 16,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RSTVAL    = {WIDTH{1'b0}},
    parameter int               DW        = bb_delay_w(MAX_DELAY)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DW-1:0]    delay_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             filling_o,
    output logic             clamp_o
);

    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    // Saturate the requested delay to the buffer depth.
    function automatic logic [DW-1:0] sat_delay(input logic [DW-1:0] d);
        return (d > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : d;
    endfunction

    bb_state_t        state, state_nxt;
    logic [DW-1:0]    d_lat, d_lat_nxt;
    logic [DW-1:0]    fill_cnt, fill_nxt;
    logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr;
    logic [DW-1:0]    d_eff;
    logic             dly_chg;
    logic             over;
    logic             wr_en;
    logic             out_en;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic             clamp_q;

    // Reset wins over valid_i, so the sample on a reset cycle never reaches the buffer.
    assign wr_en = valid_i && !reset;

    bb_var_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DELAY),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Next-state, pointer and output-load decisions.
    always_comb begin
        d_eff      = sat_delay(delay_i);
        over       = delay_i > DW'(MAX_DELAY);
        dly_chg    = d_eff != d_lat;
        rd_ptr     = AW'(bb_mod_sub(32'(wr_ptr), 32'(d_lat), 32'(MAX_DELAY)));
        wr_ptr_nxt = wr_ptr;
        state_nxt  = state;
        fill_nxt   = fill_cnt;
        d_lat_nxt  = d_lat;
        out_en     = 1'b0;
        out_data   = rd_data;

        if (valid_i) begin
            wr_ptr_nxt = (wr_ptr == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr + AW'(1);
        end

        if (dly_chg) begin
            // Restart: a sample arriving now is fill sample 0 of the new delay.
            d_lat_nxt = d_eff;
            fill_nxt  = valid_i ? DW'(1) : '0;
            if (d_eff == '0 || (valid_i && d_eff == DW'(1))) begin
                state_nxt = RUN;
            end else begin
                state_nxt = FILL;
            end
        end else if (valid_i) begin
            case (state)
                FILL: begin
                    fill_nxt = fill_cnt + DW'(1);
                    if (fill_cnt == d_lat - DW'(1)) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    out_en   = 1'b1;
                    out_data = (d_lat == '0) ? data_i : rd_data;
                end
                default: ;
            endcase
        end
    end

    // State, pointer and registered-output update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FILL;
            d_lat    <= '0;
            fill_cnt <= '0;
            wr_ptr   <= '0;
            clamp_q  <= 1'b0;
            vld_p1   <= 1'b0;
            data_p1  <= RSTVAL;
        end else begin
            state    <= state_nxt;
            d_lat    <= d_lat_nxt;
            fill_cnt <= fill_nxt;
            wr_ptr   <= wr_ptr_nxt;
            clamp_q  <= clamp_q | over;
            vld_p1   <= out_en;
            if (out_en) begin
                data_p1 <= out_data;
            end
        end
    end

    assign data_o    = data_p1;
    assign valid_o   = vld_p1;
    assign filling_o = (state == FILL);
    assign clamp_o   = clamp_q;

endmodule

// File: tb/tb_bb_var.sv
// Directed bench for bb_var: a 16-deep instance driven from a vector table and
// loops, plus a 12-deep instance exercising non-power-of-two wrap.
module tb_bb_var;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] d16;
    logic [7:0] din16;
    logic       v16;
    logic [7:0] do16;
    logic       vo16, fo16, co16;

    logic [3:0] d12;
    logic [7:0] din12;
    logic       v12;
    logic [7:0] do12;
    logic       vo12, fo12, co12;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] d;
        logic [7:0] din;
        logic       ev;
        logic [7:0] edo;
        logic       ef;
        logic       ec;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    bb_var #(.MAX_DELAY(16), .WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .delay_i   (d16),
        .data_i    (din16),
        .valid_i   (v16),
        .data_o    (do16),
        .valid_o   (vo16),
        .filling_o (fo16),
        .clamp_o   (co16)
    );

    bb_var #(.MAX_DELAY(12), .WIDTH(8)) dut12 (
        .clock     (clock),
        .reset     (reset),
        .delay_i   (d12),
        .data_i    (din12),
        .valid_i   (v12),
        .data_o    (do12),
        .valid_o   (vo12),
        .filling_o (fo12),
        .clamp_o   (co12)
    );

    function automatic void add(input logic rst, input logic v, input logic [4:0] d,
                                input logic [7:0] din, input logic ev, input logic [7:0] edo,
                                input logic ef, input logic ec);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.din = din;
        r.ev = ev; r.edo = edo; r.ef = ef; r.ec = ec;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s @vec %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge pass, then sample outputs.
    task automatic step();
        @(posedge clock);
        #1;
        nvec++;
    endtask

    task automatic chk16(input int idx, input logic ev, input logic [7:0] edo,
                         input logic ef, input logic ec);
        chk("valid16", idx, 8'(vo16), 8'(ev));
        chk("data16", idx, do16, edo);
        chk("filling16", idx, 8'(fo16), 8'(ef));
        chk("clamp16", idx, 8'(co16), 8'(ec));
    endtask

    task automatic chk12(input int idx, input logic ev, input logic [7:0] edo, input logic ef);
        chk("valid12", idx, 8'(vo12), 8'(ev));
        chk("data12", idx, do12, edo);
        chk("filling12", idx, 8'(fo12), 8'(ef));
        chk("clamp12", idx, 8'(co12), 8'h00);
    endtask

    initial begin
        reset = 1'b1; v16 = 1'b0; d16 = 5'd3; din16 = 8'h00;
        v12 = 1'b0; d12 = 4'd12; din12 = 8'h00;

        // Reset with valid toggling, then release.
        add(1, 1, 3, 8'h11, 0, 8'h00, 1, 0);
        add(1, 0, 3, 8'h22, 0, 8'h00, 1, 0);
        add(1, 1, 3, 8'h33, 0, 8'h00, 1, 0);
        add(0, 0, 3, 8'h00, 0, 8'h00, 1, 0);
        // D=3 contiguous 1..8.
        add(0, 1, 3, 8'd1, 0, 8'd0, 1, 0);
        add(0, 1, 3, 8'd2, 0, 8'd0, 1, 0);
        add(0, 1, 3, 8'd3, 0, 8'd0, 0, 0);
        for (int k = 4; k <= 8; k++) add(0, 1, 3, 8'(k), 1, 8'(k - 3), 0, 0);
        add(0, 0, 3, 8'd0, 0, 8'd5, 0, 0);
        // D=2 gapped: 10,20,30,40 with two idle cycles between.
        add(0, 0, 2, 8'd0, 0, 8'd5, 1, 0);
        add(0, 1, 2, 8'd10, 0, 8'd5, 1, 0);
        add(0, 0, 2, 8'd0, 0, 8'd5, 1, 0);
        add(0, 0, 2, 8'd0, 0, 8'd5, 1, 0);
        add(0, 1, 2, 8'd20, 0, 8'd5, 0, 0);
        add(0, 0, 2, 8'd0, 0, 8'd5, 0, 0);
        add(0, 0, 2, 8'd0, 0, 8'd5, 0, 0);
        add(0, 1, 2, 8'd30, 1, 8'd10, 0, 0);
        add(0, 0, 2, 8'd0, 0, 8'd10, 0, 0);
        add(0, 0, 2, 8'd0, 0, 8'd10, 0, 0);
        add(0, 1, 2, 8'd40, 1, 8'd20, 0, 0);
        add(0, 0, 2, 8'd0, 0, 8'd20, 0, 0);
        // Bypass D=0.
        add(0, 0, 0, 8'h00, 0, 8'd20, 0, 0);
        add(0, 1, 0, 8'hA5, 1, 8'hA5, 0, 0);
        add(0, 1, 0, 8'h5A, 1, 8'h5A, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h5A, 0, 0);
        // D=4 with ten samples 0x60..0x69.
        add(0, 0, 4, 8'h00, 0, 8'h5A, 1, 0);
        for (int k = 0; k < 10; k++)
            add(0, 1, 4, 8'(8'h60 + k), (k >= 4), (k >= 4) ? 8'(8'h60 + k - 4) : 8'h5A, (k < 3), 0);
        // Switch to D=2 with a sample on the change cycle.
        add(0, 1, 2, 8'h6A, 0, 8'h65, 1, 0);
        add(0, 1, 2, 8'h6B, 0, 8'h65, 0, 0);
        add(0, 1, 2, 8'h6C, 1, 8'h6A, 0, 0);
        add(0, 1, 2, 8'h6D, 1, 8'h6B, 0, 0);
        // Over-range request clamps to 16 and sets the sticky flag.
        add(0, 0, 31, 8'h00, 0, 8'h6B, 1, 1);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; v16 = tbl[i].v; d16 = tbl[i].d; din16 = tbl[i].din;
            step();
            chk16(i, tbl[i].ev, tbl[i].edo, tbl[i].ef, tbl[i].ec);
            chk("idle12_valid", i, 8'(vo12), 8'h00);
            chk("idle12_fill", i, 8'(fo12), 8'h01);
        end

        // Samples 0..39 into both depths: clamped D=16 and D=12, across pointer wrap.
        for (int k = 0; k < 40; k++) begin
            v16 = 1'b1; d16 = 5'd31; din16 = 8'(k);
            v12 = 1'b1; d12 = 4'd12; din12 = 8'(k);
            step();
            chk16(1000 + k, (k >= 16), (k >= 16) ? 8'(k - 16) : 8'h6B, (k < 15), 1'b1);
            chk12(1000 + k, (k >= 12), (k >= 12) ? 8'(k - 12) : 8'h00, (k < 11));
        end

        // Requesting exactly 16 after the clamp matches the clamped delay: no refill.
        d16 = 5'd16; din16 = 8'd40; din12 = 8'd40;
        step();
        chk16(1040, 1'b1, 8'd24, 1'b0, 1'b1);
        chk12(1040, 1'b1, 8'd28, 1'b0);

        // Mid-stream reset with valid high: sample dropped, flags cleared.
        reset = 1'b1; d16 = 5'd3; din16 = 8'd41; din12 = 8'd41;
        step();
        chk16(1100, 1'b0, 8'h00, 1'b1, 1'b0);
        chk12(1100, 1'b0, 8'h00, 1'b1);

        // First valid sample after release starts a fresh fill.
        reset = 1'b0; din16 = 8'h77; din12 = 8'h77;
        step();
        chk16(1101, 1'b0, 8'h00, 1'b1, 1'b0);
        chk12(1101, 1'b0, 8'h00, 1'b1);

        v16 = 1'b0; v12 = 1'b0;
        step();
        chk16(1102, 1'b0, 8'h00, 1'b1, 1'b0);
        chk12(1102, 1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
